// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module : mem_port_arbiter_if
// Brief  : Request/grant and memory handshake bundle for mem_port_arbiter.
// Rev    : 1.0  initial release
// ============================================================================
interface mem_port_arbiter_if;
  logic [2:0] req;
  logic       mem_r;
  logic       err_clr;
  logic [1:0] sel;
  logic [2:0] gnt;
  logic       mem_en;
  logic [2:0] done;
  logic       busy;
  logic       timeout_err;

  // master: requesters and memory side; slave: the arbiter itself
  modport master (
    output req, mem_r, err_clr,
    input  sel, gnt, mem_en, done, busy, timeout_err
  );

  modport slave (
    input  req, mem_r, err_clr,
    output sel, gnt, mem_en, done, busy, timeout_err
  );
endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module : mem_port_arbiter
// Brief  : Round-robin arbiter/sequencer for the shared 16-bit memory port.
//          Optional ACCESS timeout enabled by defining MEM_ARB_TIMEOUT_EN.
// Rev    : 1.0  initial release
// ============================================================================
module mem_port_arbiter #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  mem_port_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] c_timeout  = CNT_W'(TIMEOUT);
  localparam logic [1:0]       c_sel_idle = 2'd3;

  state_t     r_state, w_state_nxt;
  logic [1:0] r_sel, w_sel_nxt;
  logic [2:0] r_gnt, w_gnt_nxt;
  logic       r_mem_en, w_mem_en_nxt;
  logic [2:0] r_done, w_done_nxt;
  logic       r_busy;
  logic [1:0] r_last, w_last_nxt;
  logic [1:0] w_winner;
  logic       w_timeout_hit;

  // Scan starts just after the last winner; only meaningful when req != 0.
  always_comb begin
    w_winner = 2'd0;
    case (r_last)
      2'd0:    w_winner = bus.req[1] ? 2'd1 : (bus.req[2] ? 2'd2 : 2'd0);
      2'd1:    w_winner = bus.req[2] ? 2'd2 : (bus.req[0] ? 2'd0 : 2'd1);
      default: w_winner = bus.req[0] ? 2'd0 : (bus.req[1] ? 2'd1 : 2'd2);
    endcase
  end

`ifdef MEM_ARB_TIMEOUT_EN
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             r_timeout_err;

  assign w_cnt_inc     = r_cnt + 1'b1;
  assign w_timeout_hit = !bus.mem_r && (w_cnt_inc == c_timeout);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt         <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      if (r_state != ST_ACCESS)
        r_cnt <= '0;
      else if (!bus.mem_r)
        r_cnt <= w_cnt_inc;
      // set has priority over a simultaneous clear
      if (r_state == ST_ACCESS && w_timeout_hit)
        r_timeout_err <= 1'b1;
      else if (bus.err_clr)
        r_timeout_err <= 1'b0;
    end
  end

  assign bus.timeout_err = r_timeout_err;
`else
  logic w_unused;

  assign w_timeout_hit   = 1'b0;
  assign w_unused        = ^{bus.err_clr, c_timeout};
  assign bus.timeout_err = 1'b0;
`endif

  always_comb begin
    w_state_nxt  = r_state;
    w_sel_nxt    = r_sel;
    w_gnt_nxt    = r_gnt;
    w_mem_en_nxt = r_mem_en;
    w_done_nxt   = 3'b000;
    w_last_nxt   = r_last;
    case (r_state)
      ST_IDLE: begin
        w_sel_nxt    = c_sel_idle;
        w_gnt_nxt    = 3'b000;
        w_mem_en_nxt = 1'b0;
        if (bus.req != 3'b000) begin
          w_state_nxt  = ST_ACCESS;
          w_sel_nxt    = w_winner;
          w_gnt_nxt    = 3'b001 << w_winner;
          w_mem_en_nxt = 1'b1;
          w_last_nxt   = w_winner;
        end
      end
      ST_ACCESS: begin
        if (bus.mem_r || w_timeout_hit) begin
          w_state_nxt  = ST_DONE;
          w_mem_en_nxt = 1'b0;
          w_done_nxt   = r_gnt;
        end
      end
      ST_DONE: begin
        w_state_nxt  = ST_IDLE;
        w_sel_nxt    = c_sel_idle;
        w_gnt_nxt    = 3'b000;
        w_mem_en_nxt = 1'b0;
      end
      default: begin
        w_state_nxt  = ST_IDLE;
        w_sel_nxt    = c_sel_idle;
        w_gnt_nxt    = 3'b000;
        w_mem_en_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_sel    <= c_sel_idle;
      r_gnt    <= 3'b000;
      r_mem_en <= 1'b0;
      r_done   <= 3'b000;
      r_busy   <= 1'b0;
      r_last   <= 2'd2;
    end else begin
      r_state  <= w_state_nxt;
      r_sel    <= w_sel_nxt;
      r_gnt    <= w_gnt_nxt;
      r_mem_en <= w_mem_en_nxt;
      r_done   <= w_done_nxt;
      r_busy   <= (w_state_nxt != ST_IDLE);
      r_last   <= w_last_nxt;
    end
  end

  assign bus.sel    = r_sel;
  assign bus.gnt    = r_gnt;
  assign bus.mem_en = r_mem_en;
  assign bus.done   = r_done;
  assign bus.busy   = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_mem_port_arbiter
// Brief  : Directed self-checking bench for mem_port_arbiter.
// Rev    : 1.0  initial release
// ============================================================================
module tb_mem_port_arbiter;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int c_to = 4;
`else
  localparam int c_to = 255;
`endif

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  mem_port_arbiter_if bus ();

  mem_port_arbiter #(.TIMEOUT(c_to), .CNT_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {busy, mem_en, done, gnt, sel}
  function automatic logic [15:0] pk(input logic b, input logic m,
                                     input logic [2:0] d, input logic [2:0] g,
                                     input logic [1:0] s);
    return {6'd0, b, m, d, g, s};
  endfunction

  function automatic logic [15:0] obs_v();
    return pk(bus.busy, bus.mem_en, bus.done, bus.gnt, bus.sel);
  endfunction

  function automatic logic [15:0] exp_idle();
    return pk(1'b0, 1'b0, 3'b000, 3'b000, 2'd3);
  endfunction

  function automatic logic [15:0] exp_acc(input logic [1:0] w);
    return pk(1'b1, 1'b1, 3'b000, 3'(3'b001 << w), w);
  endfunction

  function automatic logic [15:0] exp_done(input logic [1:0] w);
    return pk(1'b1, 1'b0, 3'(3'b001 << w), 3'(3'b001 << w), w);
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [1:0] seq [6];
    seq = '{2'd1, 2'd2, 2'd0, 2'd1, 2'd2, 2'd0};
    n_cmp       = 0;
    n_err       = 0;
    rst_n       = 1'b1;
    bus.req     = 3'b000;
    bus.mem_r   = 1'b0;
    bus.err_clr = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("reset_async", obs_v(), exp_idle());
    chk("reset_terr", 16'(bus.timeout_err), 16'd0);
    step();
    step();
    chk("reset_held", obs_v(), exp_idle());
    rst_n = 1'b1;

    // no requests: stays idle
    for (int i = 0; i < 5; i++) begin
      step();
      chk("idle", obs_v(), exp_idle());
    end

    // single access from requester 0, mem_r in third ACCESS cycle
    bus.req = 3'b001;
    step();
    chk("t2_acc1", obs_v(), exp_acc(2'd0));
    step();
    chk("t2_acc2", obs_v(), exp_acc(2'd0));
    step();
    chk("t2_acc3", obs_v(), exp_acc(2'd0));
    bus.mem_r = 1'b1;
    step();
    chk("t2_done", obs_v(), exp_done(2'd0));
    bus.mem_r = 1'b0;
    bus.req   = 3'b000;
    step();
    chk("t2_idle", obs_v(), exp_idle());

    // all requesting, mem_r tied high; last winner was 0 so rotation starts at 1
    bus.req   = 3'b111;
    bus.mem_r = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("rr_acc", obs_v(), exp_acc(seq[i]));
      step();
      chk("rr_done", obs_v(), exp_done(seq[i]));
      step();
      chk("rr_idle", obs_v(), exp_idle());
    end
    bus.req   = 3'b000;
    bus.mem_r = 1'b0;

    // requester 1 drops its request mid-access, requester 2 raises
    step();
    bus.req = 3'b010;
    step();
    chk("t4_acc", obs_v(), exp_acc(2'd1));
    bus.req = 3'b100;
    step();
    chk("t4_hold1", obs_v(), exp_acc(2'd1));
    step();
    chk("t4_hold2", obs_v(), exp_acc(2'd1));
    bus.mem_r = 1'b1;
    step();
    chk("t4_done", obs_v(), exp_done(2'd1));
    bus.mem_r = 1'b0;
    step();
    chk("t4_idle", obs_v(), exp_idle());
    step();
    chk("t4_acc2", obs_v(), exp_acc(2'd2));

    // asynchronous reset during an access to requester 2
    rst_n = 1'b0;
    #1;
    chk("t5_rst_async", obs_v(), exp_idle());
    step();
    chk("t5_rst_nodone", obs_v(), exp_idle());
    rst_n = 1'b1;
    step();
    chk("t5_acc", obs_v(), exp_acc(2'd2));
    bus.mem_r = 1'b1;
    step();
    chk("t5_done", obs_v(), exp_done(2'd2));
    bus.mem_r = 1'b0;
    bus.req   = 3'b000;
    step();
    chk("t5_idle", obs_v(), exp_idle());
    chk("t5_terr", 16'(bus.timeout_err), 16'd0);

`ifdef MEM_ARB_TIMEOUT_EN
    // mem_r never arrives: abort after TIMEOUT ACCESS cycles
    bus.req = 3'b001;
    for (int i = 0; i < c_to; i++) begin
      step();
      chk("to_acc", obs_v(), exp_acc(2'd0));
    end
    step();
    chk("to_done", obs_v(), exp_done(2'd0));
    chk("to_err_set", 16'(bus.timeout_err), 16'd1);
    bus.req = 3'b000;
    step();
    chk("to_idle", obs_v(), exp_idle());
    chk("to_err_sticky", 16'(bus.timeout_err), 16'd1);
    bus.err_clr = 1'b1;
    step();
    bus.err_clr = 1'b0;
    chk("to_err_clr", 16'(bus.timeout_err), 16'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
